// File: rtl/count.sv
// count: WIDTH-bit up/down counter. mode=1 counts up, mode=0 counts down,
// wrapping modulo 2^WIDTH on every rising clock edge. rstn clears the counter
// asynchronously. out comes straight from the counter register.
module count #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             mode,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next value: step by one in the direction selected by mode.
  // Natural WIDTH-bit overflow gives the required wrap in both directions.
  always_comb begin
    cnt_d = cnt_q;
    if (mode) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Registered output only: there is no combinational path from mode to out.
  assign out = cnt_q;

endmodule

// File: tb/tb_count.sv
// tb_count: self-checking bench for count. It covers a reset hold, a vector
// table, hand-written async-reset sequences and a randomised run that is
// checked against a modulo-16 arithmetic model.
module tb_count;

  logic       clk;
  logic       rstn;
  logic       mode;
  logic [3:0] out;

  int checks;
  int errors;

  typedef struct {
    logic       rstn;
    logic       mode;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[$];

  count #(
    .WIDTH(4)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .mode (mode),
    .out  (out)
  );

  // Rising edges occur at 5, 15, 25, ... time units.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input logic r, input logic m, input logic [3:0] e);
    vec_t v;
    v.rstn = r;
    v.mode = m;
    v.exp  = e;
    vecs.push_back(v);
  endtask

  // Advance one rising edge, then sample 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_val;
    logic rst_now;

    checks = 0;
    errors = 0;

    // Table: up 17 edges with wrap, up to 5, change direction, then reset and count down with wrap.
    for (int i = 1; i <= 17; i++) add_vec(1'b1, 1'b1, 4'((i) % 16));
    for (int i = 2; i <= 5; i++) add_vec(1'b1, 1'b1, 4'(i));
    add_vec(1'b1, 1'b0, 4'h4);
    add_vec(1'b1, 1'b0, 4'h3);
    add_vec(1'b0, 1'b0, 4'h0);
    add_vec(1'b1, 1'b0, 4'hF);
    add_vec(1'b1, 1'b0, 4'hE);
    add_vec(1'b1, 1'b0, 4'hD);

    // Reset hold: rstn low for 200 units, mode rises at t=30.
    rstn = 1'b0;
    mode = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      #10;
      check("reset_hold", out, 4'h0);
      if (i == 3) mode = 1'b1;
    end

    // Release reset between edges at t=200 and then apply the table.
    for (int i = 0; i < vecs.size(); i++) begin
      rstn = vecs[i].rstn;
      mode = vecs[i].mode;
      tick();
      check($sformatf("vec%0d", i), out, vecs[i].exp);
    end

    // Count up to 9, then drop rstn between edges and check the async clear.
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
    mode = 1'b1;
    for (int i = 1; i <= 9; i++) tick();
    check("count_to_9", out, 4'h9);
    #2;
    rstn = 1'b0;
    #1;
    check("async_clear", out, 4'h0);
    for (int i = 0; i < 4; i++) begin
      mode = ~mode;
      tick();
      check("reset_hold_toggle", out, 4'h0);
    end
    rstn = 1'b1;
    mode = 1'b1;
    tick();
    check("after_release_up", out, 4'h1);

    // Random run against the arithmetic model.
    exp_val = 1;
    for (int i = 0; i < 300; i++) begin
      rst_now = ($urandom_range(0, 15) == 0);
      mode    = 1'($urandom_range(0, 1));
      rstn    = ~rst_now;
      #1;
      if (rst_now) begin
        exp_val = 0;
        check("rand_async", out, 4'h0);
      end
      tick();
      if (!rst_now) exp_val = (exp_val + (mode ? 1 : 15)) % 16;
      check("rand", out, 4'(exp_val));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
